// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequential radix-4 Booth multiplier, 32x32 signed -> 64.
// One Booth digit per BUSY cycle; valid/ready on both operand and result sides.
//
// Ports:
//   clk, rst (async, active-high)
//   start_valid / start_ready, x, y    : operand handshake
//   busy, booth_sign/one/two, digit_idx : current digit (0 when not busy)
//   res_valid / res_ready, product     : result handshake
//
// Option: define BOOTH_SEQ_SKIP_ZERO_EN to finish early once the remaining
// multiplier digits are all zero.
module booth_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        booth_sign,
    output logic        booth_one,
    output logic        booth_two,
    output logic [3:0]  digit_idx,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] product
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] xr;
    logic [31:0] yr;
    logic [63:0] acc;
    logic [63:0] acc_nx;
    logic [63:0] prod;
    logic [3:0]  idx;

    logic [32:0] yext;
    logic [5:0]  bpos;
    logic        b2, b1, b0;
    logic        d_sign, d_one, d_two;
    logic [63:0] xs;
    logic [63:0] mag;
    logic [63:0] term;
    logic        last;

`ifdef BOOTH_SEQ_SKIP_ZERO_EN
    logic [31:0] yhi;
`endif

    // Digit extraction and accumulate term for the digit at idx
    always_comb begin
        yext   = {yr, 1'b0};              // y[-1] = 0 lives at bit 0
        bpos   = {1'b0, idx, 1'b0};
        b2     = yext[bpos + 6'd2];
        b1     = yext[bpos + 6'd1];
        b0     = yext[bpos];
        d_one  = b1 ^ b0;
        d_two  = (b2 & ~b1 & ~b0) | (~b2 & b1 & b0);
        d_sign = b2 & ~(b1 & b0);
        xs     = {{32{xr[31]}}, xr};
        mag    = '0;
        if (d_one)
            mag = xs;
        else if (d_two)
            mag = xs << 1;
        term   = d_sign ? (~mag + 64'd1) : mag;
        acc_nx = acc + (term << bpos);
    end

    // Last digit: fixed 16, or earlier once the upper multiplier bits are
    // pure sign extension (every remaining digit is then zero)
`ifdef BOOTH_SEQ_SKIP_ZERO_EN
    always_comb begin
        yhi  = $signed(yr) >>> (bpos[4:0] + 5'd1);
        last = (idx == 4'd15) || (yhi == 32'd0) || (yhi == 32'hFFFF_FFFF);
    end
`else
    always_comb begin
        last = (idx == 4'd15);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start_valid) state_nx = S_BUSY;
            S_BUSY: if (last)        state_nx = S_DONE;
            S_DONE: if (res_ready)   state_nx = S_IDLE;
            default:                 state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr   <= '0;
            yr   <= '0;
            acc  <= '0;
            idx  <= '0;
            prod <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        xr  <= x;
                        yr  <= y;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                S_BUSY: begin
                    acc <= acc_nx;
                    idx <= idx + 4'd1;
                    if (last)
                        prod <= acc_nx;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        start_ready = (state == S_IDLE);
        busy        = (state == S_BUSY);
        res_valid   = (state == S_DONE);
        booth_sign  = busy & d_sign;
        booth_one   = busy & d_one;
        booth_two   = busy & d_two;
        digit_idx   = busy ? idx : 4'd0;
        product     = prod;
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: randomized scoreboard bench for booth_seq_ctrl.
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_booth_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        booth_sign;
    logic        booth_one;
    logic        booth_two;
    logic [3:0]  digit_idx;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] product;

    booth_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .booth_sign (booth_sign),
        .booth_one  (booth_one),
        .booth_two  (booth_two),
        .digit_idx  (digit_idx),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .product    (product)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] p;
        int          lat;
    } exp_t;

    exp_t        q[$];
    logic        active  = 1'b0;
    logic [31:0] cur_y   = '0;
    int          acc_cyc = 0;

    function automatic logic [63:0] model_prod(logic [31:0] a, logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return pa * pb;
    endfunction

    // Cycles needed: 16, or with early finish the fewest digits n such that
    // y fits in a signed 2n-bit number.
    function automatic int model_lat(logic [31:0] b);
`ifdef BOOTH_SEQ_SKIP_ZERO_EN
        longint v;
        longint lim;
        v = longint'($signed(b));
        for (int n = 1; n <= 16; n++) begin
            lim = longint'(1) << (2 * n - 1);
            if (v >= -lim && v < lim)
                return n;
        end
        return 16;
`else
        return (b === 32'hx) ? 0 : 16;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor
    logic        prev_rv = 1'b0;
    logic [63:0] held    = '0;

    always @(negedge clk) begin
        int          i;
        int          d;
        logic [3:0]  ei;
        exp_t        e;
        if (rst) begin
            prev_rv = 1'b0;
        end else begin
            if (busy && active) begin
                i  = cyc - acc_cyc;
                ei = i[3:0];
                d  = 0;
                if (i >= 0 && i < 16) begin
                    // digit value = -2*y[2i+1] + y[2i] + y[2i-1]
                    d = -2 * int'(cur_y[2*i+1]) + int'(cur_y[2*i]);
                    if (i > 0)
                        d = d + int'(cur_y[2*i-1]);
                end
                check("digit", {60'd0, digit_idx, booth_sign, booth_one, booth_two},
                      {60'd0, ei, d < 0, d == 1 || d == -1, d == 2 || d == -2});
            end
            if (!busy)
                check("idle_digit", {57'd0, digit_idx, booth_sign, booth_one, booth_two},
                      64'd0);
            if (res_valid && !prev_rv) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("product", product, e.p);
                    check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
                end
                held   = product;
                active = 1'b0;
            end else if (res_valid && prev_rv) begin
                check("product_hold", product, held);
            end
            prev_rv = res_valid;
        end
    end

    task automatic pulse_reset();
        rst = 1'b1;
        q.delete();
        active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one operand pair; leaves the DUT busy
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        n = 0;
        while (!start_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("start_ready_wait", 64'(start_ready), 64'd1);
        start_valid = 1'b1;
        x = a;
        y = b;
        e.p = model_prod(a, b);
        e.lat = model_lat(b);
        q.push_back(e);
        cur_y = b;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        active = 1'b1;
        start_valid = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int n;
        issue(a, b);
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 40) begin
            start_valid = 1'($urandom % 2);
            x = $urandom;
            y = $urandom;
            res_ready = 1'($urandom % 2);
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            check("result_timeout", 64'd1, 64'd0);
            pulse_reset();
            return;
        end
        for (int k = 0; k < hold; k++) begin
            res_ready = 1'b0;
            start_valid = 1'($urandom % 2);
            x = $urandom;
            y = $urandom;
            @(negedge clk);
            check("done_hold", {61'd0, start_ready, res_valid, busy}, 64'b010);
        end
        res_ready = 1'b1;
        start_valid = 1'($urandom % 2);
        @(negedge clk);
        check("back_to_idle", {61'd0, start_ready, res_valid, busy}, 64'b100);
        res_ready = 1'b0;
        start_valid = 1'b0;
    endtask

    task automatic reset_mid_op(input logic [31:0] a, input logic [31:0] b);
        int n;
        issue(a, b);
        n = 0;
        @(negedge clk);
        while (!(busy && digit_idx == 4'd7) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_digit7", 64'(digit_idx), 64'd7);
        rst = 1'b1;
        #1;
        check("rst_abort", {61'd0, busy, res_valid, start_ready}, 64'b001);
        check("rst_digit", {59'd0, digit_idx, booth_sign}, 64'd0);
        check("rst_product", product, 64'd0);
        void'(q.pop_back());
        active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        x = '0;
        y = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {61'd0, start_ready, busy, res_valid}, 64'b100);
        check("reset_product", product, 64'd0);
        check("reset_digit", {57'd0, digit_idx, booth_sign, booth_one, booth_two}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'h0000_110F, 32'h0000_0003, 0);
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op(32'h8000_0000, 32'h8000_0000, 5);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1);
        run_op(32'h0000_0005, 32'h0000_0000, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        reset_mid_op(32'h1234_5678, 32'h8000_0001);
        run_op(32'h1234_5678, 32'h8000_0001, 1);

        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom % 2)
                b = $signed(b) >>> ($urandom % 32);
            run_op(a, b, int'($urandom % 4));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
